uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//   Parametrised UART transmitter; successor to the fixed-format uart_tx.
//   - Serialises one parallel word per frame: start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
//   - Each bit lasts CLK_DIV clocks; uses an internal bit-rate counter, so no external baud clock is needed.
//   - Accepts words through a valid/ready handshake; drives the serial line Dout.
// PARAMETERS
//   CLK_DIV    16  clock cycles per serial bit; must be >= 2
//   DATA_BITS  8   data bits per frame; legal range 5..9
//   PARITY     0   0 = none, 1 = odd, 2 = even
//   STOP_BITS  1   number of stop bits; 1 or 2
// PORTS
//   clk       in   1          system clock; all logic on rising edge
//   rst       in   1          synchronous, active-high reset
//   tx_data   in   DATA_BITS  word to send; sampled only on a handshake
//   tx_valid  in   1          tx_data is valid
//   tx_ready  out  1          block can accept a word; high only in IDLE
//   busy      out  1          frame in progress; high in every state except IDLE
//   Dout      out  1          serial line; idles high
// BEHAVIOUR
//   Reset
//     - rst high at a clock edge forces: state = IDLE, Dout = 1, busy = 0, tx_ready = 1.
//     - Bit counter, bit index and shift register all clear to 0.
//     - Applies mid-frame: the frame is abandoned and Dout is 1 from the next cycle. No partial stop bit is sent.
//   Handshake
//     - A word is accepted at an edge where tx_valid && tx_ready.
//     - tx_data is copied into the shift register. Parity is computed from the stored copy.
//     - tx_valid while not ready is ignored; no queuing and no error flag.
//     - tx_data may change freely after acceptance.
//   FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
//     - IDLE: Dout = 1. On handshake go to START; on the same edge tx_ready = 0 and busy = 1.
//     - START: Dout = 0 for CLK_DIV cycles.
//     - DATA: Dout = shreg[0] and shreg shifts right after each bit; CLK_DIV cycles per bit; DATA_BITS bits.
//     - PARITY: present only when PARITY != 0; 1 bit of CLK_DIV cycles.
//       Odd: Dout = ~^data. Even: Dout = ^data.
//     - STOP: Dout = 1 for STOP_BITS*CLK_DIV cycles, then IDLE.
//   Timing
//     - Bit counter width is $clog2(CLK_DIV). It counts 0..CLK_DIV-1 and wraps to 0 on a bit boundary.
//     - The state or bit index advances on the wrap.
//     - Latency: Dout falls on the edge that accepts the word; there is no added delay.
//     - Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV cycles.
//     - After the last stop-bit cycle the FSM spends at least 1 cycle in IDLE, so back-to-back frames are separated by exactly one idle clock.
//   Outputs and parameter checks
//     - All outputs are registered. Dout has no glitches between bits.
//     - Illegal parameter values are rejected at elaboration by a generate-time $error.
// TESTING
//   Check every case against a cycle-accurate reference model.
//   1. Reset behaviour
//      - Stimulus: rst high 2 cycles, then low; tx_valid = 0.
//      - Required: Dout = 1, busy = 0, tx_ready = 1 throughout, with no toggles.
//   2. Single frame, 8E1
//      - Config: CLK_DIV = 4, DATA_BITS = 8, PARITY = 2, STOP_BITS = 1; send 0xA5.
//      - Dout bit sequence: 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1.
//      - Each bit lasts 4 clocks; busy stays high for 44 clocks.
//   3. Odd parity, 2 stop bits, 7-bit data
//      - Config: DATA_BITS = 7, PARITY = 1, STOP_BITS = 2, CLK_DIV = 4; send 0x03.
//      - Required: parity bit = 1; stop level held 8 clocks; frame length 44 clocks.
//   4. Back-to-back frames
//      - Stimulus: tx_valid held high with 0x55 then 0xC3 (8N1, CLK_DIV = 4).
//      - Required: second handshake exactly 1 idle cycle after the first frame's 40 clocks.
//      - Required: tx_data changes while busy are ignored.
//   5. Reset mid-frame
//      - Stimulus: assert rst during data bit 3.
//      - Required: Dout = 1 and tx_ready = 1 the next cycle.
//      - Required: the next accepted word is sent as a complete, correct frame.
//   6. Handshake while busy
//      - Stimulus: pulse tx_valid for 1 cycle mid-frame.
//      - Required: no handshake; the frame in progress is unchanged; no extra frame is sent.

Source files
------------

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity, 1 or 2 stop bits; each bit lasts CLK_DIV clocks.
module uart_tx_frame #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 busy,
  output logic                 Dout
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);

  if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_tx_frame: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bidx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic                 wrap;

  assign wrap = (cnt == CW'(CLK_DIV - 1));

  // bidx doubles as the stop-bit counter once the data bits are out
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bidx     <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      Dout     <= 1'b1;
      busy     <= 1'b0;
      tx_ready <= 1'b1;
    end else begin
      if (state != IDLE) cnt <= wrap ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
            state    <= START;
            Dout     <= 1'b0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            cnt      <= '0;
            bidx     <= '0;
          end
        end
        START: begin
          if (wrap) begin
            // shreg still holds the full word here, so parity is taken now
            par   <= (PARITY == 1) ? ~^shreg : ^shreg;
            Dout  <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (wrap) begin
            if (bidx == BW'(DATA_BITS - 1)) begin
              bidx <= '0;
              if (PARITY != 0) begin
                state <= PAR;
                Dout  <= par;
              end else begin
                state <= STOP;
                Dout  <= 1'b1;
              end
            end else begin
              bidx  <= bidx + 1'b1;
              Dout  <= shreg[0];
              shreg <= shreg >> 1;
            end
          end
        end
        PAR: begin
          if (wrap) begin
            state <= STOP;
            Dout  <= 1'b1;
          end
        end
        STOP: begin
          if (wrap) begin
            if (bidx == BW'(STOP_BITS - 1)) begin
              state    <= IDLE;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
              bidx     <= '0;
            end else begin
              bidx <= bidx + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          Dout     <= 1'b1;
          busy     <= 1'b0;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations (8E1, 7O2, 8N1, CLK_DIV=4)
// compared cycle by cycle against a frame-bit reference model.
module tb_uart_tx_frame;
  localparam int DIV = 4;
  localparam int DB[3] = '{8, 7, 8};
  localparam int PA[3] = '{2, 1, 0};
  localparam int SB[3] = '{1, 2, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] txd [3];
  logic [2:0] vld;
  logic [2:0] rdy, bsy, dout;
  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_data(txd[0][7:0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .busy(bsy[0]), .Dout(dout[0]));
  uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .tx_data(txd[1][6:0]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .busy(bsy[1]), .Dout(dout[1]));
  uart_tx_frame #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_data(txd[2][7:0]), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .busy(bsy[2]), .Dout(dout[2]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk({tag, "_dout"}, dout[k], 1'b1);
    chk({tag, "_busy"}, bsy[k], 1'b0);
    chk({tag, "_rdy"},  rdy[k], 1'b1);
  endtask

  // Called at a negedge with vld[k]=1 and txd[k]=d already driven; the next
  // posedge accepts d. Checks every cycle of the frame plus the idle cycle
  // after it. hold keeps tx_valid high and presents nxt in the last cycle;
  // pulse raises tx_valid for one cycle mid-frame.
  task automatic frame(input int k, input logic [8:0] d, input bit hold,
                       input logic [8:0] nxt, input bit pulse);
    logic bits [13];
    int   nb, len;
    logic p;
    nb = 0;
    bits[nb++] = 1'b0;
    p = 1'b0;
    for (int j = 0; j < DB[k]; j++) begin
      bits[nb++] = d[j];
      p ^= d[j];
    end
    if (PA[k] == 1) bits[nb++] = ~p;
    if (PA[k] == 2) bits[nb++] = p;
    for (int j = 0; j < SB[k]; j++) bits[nb++] = 1'b1;
    len = nb * DIV;

    chk($sformatf("u%0d_rdy_pre", k), rdy[k], 1'b1);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < len; i++) begin
      chk($sformatf("u%0d_dout_c%0d", k, i), dout[k], bits[i / DIV]);
      chk($sformatf("u%0d_busy_c%0d", k, i), bsy[k], 1'b1);
      chk($sformatf("u%0d_rdy_c%0d", k, i), rdy[k], 1'b0);
      txd[k] = (hold && i == len - 1) ? nxt : 9'($urandom);
      if (!hold) vld[k] = pulse && (i == len / 2);
      @(negedge clk);
    end
    chk_idle(k, $sformatf("u%0d_after", k));
  endtask

  initial begin
    vld = '0;
    for (int k = 0; k < 3; k++) txd[k] = '0;

    // reset: held 2 cycles, then released with no traffic
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk_idle(k, "rst_hold");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk_idle(k, "rst_rel");
    end

    // directed frames: 8E1 0xA5, 7O2 0x03
    vld[0] = 1'b1; txd[0] = 9'h0A5;
    frame(0, 9'h0A5, 1'b0, 9'h0, 1'b0);
    vld[1] = 1'b1; txd[1] = 9'h003;
    frame(1, 9'h003, 1'b0, 9'h0, 1'b0);

    // back-to-back 8N1 with tx_valid held high: 0x55 then 0xC3
    vld[2] = 1'b1; txd[2] = 9'h055;
    frame(2, 9'h055, 1'b1, 9'h0C3, 1'b0);
    frame(2, 9'h0C3, 1'b0, 9'h0, 1'b0);
    @(negedge clk);
    chk_idle(2, "b2b_end");

    // reset during data bit 3, then a clean frame
    vld[0] = 1'b1; txd[0] = 9'h0FF;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat ((1 + 3) * DIV + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle(0, "midrst");
    rst = 1'b0;
    @(negedge clk);
    chk_idle(0, "midrst_rel");
    vld[0] = 1'b1; txd[0] = 9'h05A;
    frame(0, 9'h05A, 1'b0, 9'h0, 1'b0);

    // valid pulse while busy must be ignored; no extra frame follows
    vld[1] = 1'b1; txd[1] = 9'h05C;
    frame(1, 9'h05C, 1'b0, 9'h0, 1'b1);
    for (int c = 0; c < 2 * DIV; c++) begin
      @(negedge clk);
      chk_idle(1, "no_extra");
    end

    // randomized frames on every configuration
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        logic [8:0] d;
        d = 9'($urandom);
        vld[k] = 1'b1; txd[k] = d;
        frame(k, d, 1'b0, 9'h0, r[0]);
        @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
